// File: rtl/uart_fifo.sv
// uart_fifo: parametrised UART with RX/TX FIFOs, parity, error flags and break detection
module uart_fifo_q #(
  parameter int DW = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wr, rd;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= wdata;
  assign rdata = mem[rd[AW-1:0]];
  assign level = wr - rd;
  assign empty = wr == rd;
  assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
endmodule

module uart_fifo #(
  parameter int BAUDSEL = 52,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  output logic                        tx,
  output logic                        rx_valid,
  output logic [DATA_BITS-1:0]        rx_data,
  input  logic                        rx_ready,
  output logic                        rx_break,
  output logic                        rx_frame_err,
  output logic                        rx_parity_err,
  output logic                        rx_overrun,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  input  logic                        tx_valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_level
);
  localparam int CW = $clog2(2*BAUDSEL) + 1;
  localparam logic [CW-1:0] HALF = CW'(BAUDSEL-1);
  localparam logic [CW-1:0] FULL = CW'(2*BAUDSEL-1);
  localparam logic [3:0] DLAST = 4'(DATA_BITS-1);
  localparam logic [3:0] SLAST = 4'(STOP_BITS-1);
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BRK} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  rx_state_t rx_st, rx_nx;
  logic [1:0] rx_sync;
  logic rx_s, rx_p, rx_pb, rx_tick, rx_sample, rx_brk, rx_par_bad, rx_good;
  logic rx_full, rx_empty, rx_pop, rx_push;
  logic [CW-1:0] rx_cnt;
  logic [3:0] rx_idx;
  logic [DATA_BITS-1:0] rx_sh;

  assign rx_s = rx_sync[1];
  assign rx_sample = rx_st == R_STOP && rx_tick;
  assign rx_brk = rx_sh == '0 && !rx_pb && !rx_s;
  assign rx_par_bad = PARITY != 0 && rx_pb != (^rx_sh ^ ODD);
  assign rx_good = rx_sample && rx_s && !rx_par_bad;
  assign rx_pop = rx_valid && rx_ready;
  assign rx_push = rx_good && (!rx_full || rx_pop);
  assign rx_valid = !rx_empty;
  assign rx_break = rx_st == R_BRK;

  always_comb begin
    rx_tick = rx_cnt == (rx_st == R_START ? HALF : FULL);
    rx_nx = rx_st;
    case (rx_st)
      R_IDLE:  if (rx_p && !rx_s) rx_nx = R_START;
      R_START: if (rx_tick) rx_nx = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (rx_tick && rx_idx == DLAST) rx_nx = PARITY != 0 ? R_PAR : R_STOP;
      R_PAR:   if (rx_tick) rx_nx = R_STOP;
      R_STOP:  if (rx_tick) rx_nx = rx_brk ? R_BRK : R_IDLE;
      R_BRK:   if (rx_s) rx_nx = R_IDLE;
      default: rx_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_st <= R_IDLE;
      rx_sync <= 2'b11;
      rx_p <= 1'b1;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh <= '0;
      rx_pb <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_st <= rx_nx;
      rx_sync <= {rx_sync[0], rx};
      rx_p <= rx_s;
      rx_cnt <= (rx_st != rx_nx || rx_tick) ? '0 : rx_cnt + 1'b1;
      rx_idx <= rx_st != R_DATA ? '0 : rx_tick ? rx_idx + 1'b1 : rx_idx;
      if (rx_st == R_DATA && rx_tick) rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
      if (rx_st == R_PAR && rx_tick) rx_pb <= rx_s;
      rx_frame_err <= rx_sample && !rx_brk && !rx_s;
      rx_parity_err <= rx_sample && rx_s && rx_par_bad;
      rx_overrun <= rx_good && rx_full && !rx_pop;
    end

  uart_fifo_q #(.DW(DATA_BITS), .DEPTH(RX_DEPTH)) u_rxq (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .wdata(rx_sh),
    .rdata(rx_data), .empty(rx_empty), .full(rx_full), .level(rx_level)
  );

  tx_state_t tx_st, tx_nx;
  logic tx_par, tx_tick, tx_pop, tx_push, tx_empty, tx_full, tx_bit;
  logic [CW-1:0] tx_cnt;
  logic [3:0] tx_idx;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_nx, tx_q;

  assign tx_ready = !tx_full;
  assign tx_push = tx_valid && tx_ready;

  // tx is registered from the next state so the line never glitches
  always_comb begin
    tx_tick = tx_cnt == FULL;
    tx_nx = tx_st;
    case (tx_st)
      T_IDLE:  if (!tx_empty) tx_nx = T_START;
      T_START: if (tx_tick) tx_nx = T_DATA;
      T_DATA:  if (tx_tick && tx_idx == DLAST) tx_nx = PARITY != 0 ? T_PAR : T_STOP;
      T_PAR:   if (tx_tick) tx_nx = T_STOP;
      T_STOP:  if (tx_tick && tx_idx == SLAST) tx_nx = tx_empty ? T_IDLE : T_START;
      default: tx_nx = T_IDLE;
    endcase
    tx_pop = tx_nx == T_START && tx_st != T_START;
    tx_sh_nx = tx_pop ? tx_q : (tx_st == T_DATA && tx_tick) ? tx_sh >> 1 : tx_sh;
    tx_bit = tx_nx == T_START ? 1'b0 : tx_nx == T_DATA ? tx_sh_nx[0] : tx_nx == T_PAR ? tx_par : 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_st <= T_IDLE;
      tx <= 1'b1;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st <= tx_nx;
      tx <= tx_bit;
      tx_cnt <= (tx_st != tx_nx || tx_tick) ? '0 : tx_cnt + 1'b1;
      tx_idx <= tx_st != tx_nx ? '0 : tx_tick ? tx_idx + 1'b1 : tx_idx;
      tx_sh <= tx_sh_nx;
      if (tx_pop) tx_par <= ^tx_q ^ ODD;
    end

  uart_fifo_q #(.DW(DATA_BITS), .DEPTH(TX_DEPTH)) u_txq (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .wdata(tx_data),
    .rdata(tx_q), .empty(tx_empty), .full(tx_full), .level(tx_level)
  );
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed bench for an 8N1 instance (a) and an even-parity instance (b)
module tb_uart_fifo;
  logic clk = 1'b0, reset = 1'b1, loop = 1'b0;
  always #5 clk = ~clk;

  logic a_rx_drv = 1'b1, a_tx, a_rx_valid, a_rx_ready = 1'b0, a_brk, a_fe, a_pe, a_ov;
  logic a_tx_valid = 1'b0, a_tx_ready;
  logic [7:0] a_rx_data, a_tx_data = 8'h00;
  logic [2:0] a_rx_level, a_tx_level;
  logic b_rx = 1'b1, b_tx, b_rx_valid, b_rx_ready = 1'b0, b_brk, b_fe, b_pe, b_ov;
  logic b_tx_valid = 1'b0, b_tx_ready;
  logic [7:0] b_rx_data, b_tx_data = 8'h00;
  logic [4:0] b_rx_level, b_tx_level;
  int a_fe_n = 0, a_pe_n = 0, a_ov_n = 0, b_fe_n = 0, b_pe_n = 0;
  int tests = 0, fails = 0;

  uart_fifo #(.BAUDSEL(4), .RX_DEPTH(4), .TX_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .rx(loop ? a_tx : a_rx_drv), .tx(a_tx),
    .rx_valid(a_rx_valid), .rx_data(a_rx_data), .rx_ready(a_rx_ready),
    .rx_break(a_brk), .rx_frame_err(a_fe), .rx_parity_err(a_pe), .rx_overrun(a_ov),
    .rx_level(a_rx_level), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
    .tx_ready(a_tx_ready), .tx_level(a_tx_level)
  );

  uart_fifo #(.BAUDSEL(4), .PARITY(2)) u_b (
    .clk(clk), .reset(reset), .rx(b_rx), .tx(b_tx),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data), .rx_ready(b_rx_ready),
    .rx_break(b_brk), .rx_frame_err(b_fe), .rx_parity_err(b_pe), .rx_overrun(b_ov),
    .rx_level(b_rx_level), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
    .tx_ready(b_tx_ready), .tx_level(b_tx_level)
  );

  always @(posedge clk) begin
    a_fe_n += int'(a_fe);
    a_pe_n += int'(a_pe);
    a_ov_n += int'(a_ov);
    b_fe_n += int'(b_fe);
    b_pe_n += int'(b_pe);
  end

  task automatic send(input bit sel, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) b_rx = f[i]; else a_rx_drv = f[i];
      repeat (8) @(negedge clk);
    end
    if (sel) b_rx = 1'b1; else a_rx_drv = 1'b1;
  endtask

  task automatic pop_a;
    a_rx_ready = 1'b1;
    @(negedge clk);
    a_rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++; if (a_tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", a_tx); end
    tests++; if (a_rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got %b want 0", a_rx_valid); end
    tests++; if (a_tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready got %b want 1", a_tx_ready); end
    tests++; if (a_rx_level !== 3'd0 || a_tx_level !== 3'd0) begin fails++; $display("FAIL reset_levels got %0d/%0d want 0/0", a_rx_level, a_tx_level); end
    tests++; if ({a_brk, a_fe, a_pe, a_ov} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b want 0000", {a_brk, a_fe, a_pe, a_ov}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loopback;
    logic [199:0] lg;
    logic [19:0] fr;
    int fe0, pe0, ov0;
    fe0 = a_fe_n; pe0 = a_pe_n; ov0 = a_ov_n;
    fr = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
    loop = 1'b1;
    a_tx_valid = 1'b1; a_tx_data = 8'hA5;
    @(negedge clk);
    tests++; if (a_tx !== 1'b1) begin fails++; $display("FAIL lb_pre_start got %b want 1", a_tx); end
    a_tx_data = 8'h3C;
    @(negedge clk);
    a_tx_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      lg[i] = a_tx;
      @(negedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      tests++; if (lg[8*k+4] !== fr[k]) begin fails++; $display("FAIL lb_bit%0d got %b want %b", k, lg[8*k+4], fr[k]); end
    end
    tests++; if (lg[0] !== 1'b0) begin fails++; $display("FAIL lb_start_edge got %b want 0", lg[0]); end
    tests++; if (lg[79] !== 1'b1 || lg[80] !== 1'b0) begin fails++; $display("FAIL lb_frame_len got %b%b want 10", lg[79], lg[80]); end
    tests++; if (a_rx_level !== 3'd2) begin fails++; $display("FAIL lb_rx_level got %0d want 2", a_rx_level); end
    tests++; if (a_rx_data !== 8'hA5 || a_rx_valid !== 1'b1) begin fails++; $display("FAIL lb_data0 got %h/%b want a5/1", a_rx_data, a_rx_valid); end
    pop_a;
    tests++; if (a_rx_data !== 8'h3C) begin fails++; $display("FAIL lb_data1 got %h want 3c", a_rx_data); end
    pop_a;
    tests++; if (a_rx_valid !== 1'b0) begin fails++; $display("FAIL lb_empty got %b want 0", a_rx_valid); end
    tests++; if (a_fe_n != fe0 || a_pe_n != pe0 || a_ov_n != ov0) begin fails++; $display("FAIL lb_errs got %0d/%0d/%0d want none", a_fe_n - fe0, a_pe_n - pe0, a_ov_n - ov0); end
    loop = 1'b0;
  endtask

  task automatic test_parity;
    int pe0, fe0;
    pe0 = b_pe_n; fe0 = b_fe_n;
    send(1'b1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
    repeat (20) @(negedge clk);
    tests++; if (b_pe_n != pe0 + 1) begin fails++; $display("FAIL par_bad_pulse got %0d want 1", b_pe_n - pe0); end
    tests++; if (b_rx_level !== 5'd0) begin fails++; $display("FAIL par_bad_level got %0d want 0", b_rx_level); end
    send(1'b1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
    repeat (20) @(negedge clk);
    tests++; if (b_rx_level !== 5'd1 || b_rx_data !== 8'h03) begin fails++; $display("FAIL par_good got %0d/%h want 1/03", b_rx_level, b_rx_data); end
    tests++; if (b_pe_n != pe0 + 1 || b_fe_n != fe0) begin fails++; $display("FAIL par_good_flags got pe %0d fe %0d want 1 0", b_pe_n - pe0, b_fe_n - fe0); end
  endtask

  task automatic test_break;
    int fe0;
    fe0 = a_fe_n;
    a_rx_drv = 1'b0;
    repeat (160) @(negedge clk);
    tests++; if (a_brk !== 1'b1) begin fails++; $display("FAIL brk_set got %b want 1", a_brk); end
    tests++; if (a_rx_level !== 3'd0 || a_fe_n != fe0) begin fails++; $display("FAIL brk_nopush got lvl %0d fe %0d want 0 0", a_rx_level, a_fe_n - fe0); end
    a_rx_drv = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (a_brk !== 1'b1) begin fails++; $display("FAIL brk_hold got %b want 1", a_brk); end
    @(negedge clk);
    tests++; if (a_brk !== 1'b0) begin fails++; $display("FAIL brk_clear got %b want 0", a_brk); end
    send(1'b0, {1'b1, 8'h55, 1'b0}, 10);
    repeat (20) @(negedge clk);
    tests++; if (a_rx_level !== 3'd1 || a_rx_data !== 8'h55) begin fails++; $display("FAIL brk_next got %0d/%h want 1/55", a_rx_level, a_rx_data); end
    pop_a;
  endtask

  task automatic test_overrun;
    int ov0;
    ov0 = a_ov_n;
    for (int d = 1; d <= 5; d++) send(1'b0, {1'b1, 8'(d), 1'b0}, 10);
    repeat (20) @(negedge clk);
    tests++; if (a_rx_level !== 3'd4) begin fails++; $display("FAIL ovr_level got %0d want 4", a_rx_level); end
    tests++; if (a_ov_n != ov0 + 1) begin fails++; $display("FAIL ovr_pulse got %0d want 1", a_ov_n - ov0); end
    for (int k = 1; k <= 4; k++) begin
      tests++; if (a_rx_data !== 8'(k)) begin fails++; $display("FAIL ovr_pop%0d got %h want %h", k, a_rx_data, 8'(k)); end
      pop_a;
    end
    tests++; if (a_rx_level !== 3'd0) begin fails++; $display("FAIL ovr_drain got %0d want 0", a_rx_level); end
  endtask

  task automatic test_glitch_frame;
    int fe0, pe0, ov0;
    fe0 = a_fe_n; pe0 = a_pe_n; ov0 = a_ov_n;
    a_rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    a_rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    tests++; if (a_fe_n != fe0 || a_pe_n != pe0 || a_ov_n != ov0 || a_brk !== 1'b0 || a_rx_level !== 3'd0) begin
      fails++; $display("FAIL glitch got fe %0d brk %b lvl %0d want quiet", a_fe_n - fe0, a_brk, a_rx_level);
    end
    send(1'b0, {1'b0, 8'h80, 1'b0}, 10);
    repeat (20) @(negedge clk);
    tests++; if (a_fe_n != fe0 + 1) begin fails++; $display("FAIL frame_pulse got %0d want 1", a_fe_n - fe0); end
    tests++; if (a_rx_level !== 3'd0 || a_brk !== 1'b0) begin fails++; $display("FAIL frame_nopush got %0d/%b want 0/0", a_rx_level, a_brk); end
  endtask

  task automatic test_reset_tx;
    logic [39:0] w;
    int lows;
    w = {8'h44, 8'h33, 8'h22, 8'h00, 8'h11};
    for (int i = 0; i < 5; i++) begin
      a_tx_valid = 1'b1; a_tx_data = w[8*i +: 8];
      @(negedge clk);
    end
    a_tx_valid = 1'b0;
    tests++; if (a_tx_level !== 3'd4 || a_tx_ready !== 1'b0) begin fails++; $display("FAIL tx_full got %0d/%b want 4/0", a_tx_level, a_tx_ready); end
    repeat (97) @(negedge clk);
    tests++; if (a_tx !== 1'b0 || a_tx_level !== 3'd3) begin fails++; $display("FAIL tx_mid got %b/%0d want 0/3", a_tx, a_tx_level); end
    reset = 1'b1;
    #1;
    tests++; if (a_tx !== 1'b1 || a_tx_level !== 3'd0) begin fails++; $display("FAIL tx_reset got %b/%0d want 1/0", a_tx, a_tx_level); end
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_tx === 1'b0) lows++;
    end
    tests++; if (lows != 0) begin fails++; $display("FAIL tx_silent got %0d low cycles want 0", lows); end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_parity;
    test_break;
    test_overrun;
    test_glitch_frame;
    test_reset_tx;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
